// File: rtl/mem_arbiter_mp.sv
// N-port OBI-style memory arbiter: fixed or round-robin grant onto one shared memory port,
// with an in-order outstanding-request FIFO that routes responses and errors back per port.

module mem_arbiter_mp_lane #(
  parameter int          MEM_W = 32,
  parameter int          PW    = 1,
  parameter int unsigned PORT  = 0,
  parameter bit          ALIGN = 1'b0
) (
  input  logic             pop_i,
  input  logic             err_i,
  input  logic [PW-1:0]    head_port_i,
  input  logic [MEM_W-1:0] raw_i,
  input  logic [MEM_W-1:0] aligned_i,
  output logic             rvalid_o,
  output logic             err_o,
  output logic [MEM_W-1:0] rdata_o
);
  logic own;
  assign own      = pop_i && (head_port_i == PW'(PORT));
  assign rvalid_o = own;
  assign err_o    = own && err_i;
  assign rdata_o  = ALIGN ? aligned_i : raw_i;
endmodule

module mem_arbiter_mp #(
  parameter int                   NUM_PORTS  = 3,
  parameter int                   MEM_W      = 32,
  parameter int                   MAX_OUTST  = 16,
  parameter int                   RR_MODE    = 0,
  parameter logic [NUM_PORTS-1:0] ALIGN_MASK = '0,
  localparam int                  BE_W       = MEM_W / 8,
  localparam int                  CNT_W      = $clog2(MAX_OUTST) + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            req_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  input  logic [NUM_PORTS-1:0][31:0]      addr_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS-1:0][BE_W-1:0]  be_i,
  input  logic [NUM_PORTS-1:0][MEM_W-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [NUM_PORTS-1:0][MEM_W-1:0] rdata_o,
  output logic [NUM_PORTS-1:0]            err_o,
  output logic                            mem_req_o,
  input  logic                            mem_gnt_i,
  output logic [31:0]                     mem_addr_o,
  output logic                            mem_we_o,
  output logic [BE_W-1:0]                 mem_be_o,
  output logic [MEM_W-1:0]                mem_wdata_o,
  input  logic                            mem_rvalid_i,
  input  logic                            mem_err_i,
  input  logic [MEM_W-1:0]                mem_rdata_i,
  output logic [CNT_W-1:0]                outst_cnt_o,
  output logic                            proto_err_o
);
  localparam int PW   = $clog2(NUM_PORTS);
  localparam int AW   = $clog2(MAX_OUTST);
  localparam int OFFW = $clog2(MEM_W / 32);
  localparam int OFFS = (OFFW > 0) ? OFFW : 1;

  typedef struct packed {
    logic [PW-1:0]   port;
    logic [OFFS-1:0] off;
  } ent_t;

  ent_t             fifo_q [MAX_OUTST];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    rr_q, rr_d, win;
  logic             perr_q, any_req, full, push, pop;
  logic [OFFS-1:0]  push_off;
  ent_t             head, push_ent;
  logic [MEM_W-1:0] aligned;

  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    win   = '0;
    if (RR_MODE != 0) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        idx = (int'(rr_q) + i) % NUM_PORTS;
        if (!found && req_i[idx]) begin
          win   = PW'(idx);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (req_i[i]) win = PW'(i);
    end
  end

  // full only masks this cycle's request; a same-cycle pop does not reopen it
  assign any_req   = |req_i;
  assign full      = (cnt_q == CNT_W'(MAX_OUTST));
  assign mem_req_o = any_req && !full;
  assign push      = mem_req_o && mem_gnt_i;
  assign gnt_o     = push ? (NUM_PORTS'(1) << win) : '0;

  assign mem_addr_o  = any_req ? addr_i[win]  : '0;
  assign mem_we_o    = any_req ? we_i[win]    : 1'b0;
  assign mem_be_o    = any_req ? be_i[win]    : '0;
  assign mem_wdata_o = any_req ? wdata_i[win] : '0;

  if (OFFW > 0) begin : g_off
    assign push_off = addr_i[win][OFFS+1:2];
  end else begin : g_nooff
    assign push_off = '0;
  end
  assign push_ent = {win, push_off};

  assign head    = fifo_q[rptr_q];
  assign pop     = mem_rvalid_i && (cnt_q != '0);
  assign aligned = mem_rdata_i >> {head.off, 5'b0};

  always_comb begin
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rr_d  = rr_q;
    if (push) rr_d = (win == PW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      rr_q   <= '0;
      perr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rr_q  <= rr_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (mem_rvalid_i && (cnt_q == '0)) perr_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= push_ent;
  end

  assign outst_cnt_o = cnt_q;
  assign proto_err_o = perr_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    mem_arbiter_mp_lane #(
      .MEM_W(MEM_W), .PW(PW), .PORT(p), .ALIGN(ALIGN_MASK[p])
    ) u_lane (
      .pop_i      (pop),
      .err_i      (mem_err_i),
      .head_port_i(head.port),
      .raw_i      (mem_rdata_i),
      .aligned_i  (aligned),
      .rvalid_o   (rvalid_o[p]),
      .err_o      (err_o[p]),
      .rdata_o    (rdata_o[p])
    );
  end
endmodule

// File: tb/tb_mem_arbiter_mp.sv
// Bench for mem_arbiter_mp: a fixed-priority and a round-robin instance share one stimulus stream.
module tb_mem_arbiter_mp;
  localparam int NP = 3, MW = 128, MO = 4, BW = MW / 8;
  localparam logic [MW-1:0] RDATA_K = 128'h44444444_33333333_22222222_11111111;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic [NP-1:0]          req, we;
  logic [NP-1:0][31:0]    addr;
  logic [NP-1:0][BW-1:0]  be;
  logic [NP-1:0][MW-1:0]  wdata;
  logic                   mgnt, mrv, merr;
  logic [MW-1:0]          mrdata;

  logic [NP-1:0]         gnt [2], rv [2], er [2];
  logic [NP-1:0][MW-1:0] rd [2];
  logic                  mreq [2], mwe [2], perr [2];
  logic [31:0]           maddr [2];
  logic [BW-1:0]         mbe [2];
  logic [MW-1:0]         mwd [2];
  logic [2:0]            cnt [2];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    mem_arbiter_mp #(
      .NUM_PORTS(NP), .MEM_W(MW), .MAX_OUTST(MO), .RR_MODE(m), .ALIGN_MASK(3'b001)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[m]), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rv[m]), .rdata_o(rd[m]), .err_o(er[m]),
      .mem_req_o(mreq[m]), .mem_gnt_i(mgnt), .mem_addr_o(maddr[m]), .mem_we_o(mwe[m]),
      .mem_be_o(mbe[m]), .mem_wdata_o(mwd[m]), .mem_rvalid_i(mrv), .mem_err_i(merr),
      .mem_rdata_i(mrdata), .outst_cnt_o(cnt[m]), .proto_err_o(perr[m])
    );
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: per instance, a queue of outstanding {port*4 + word offset}
  int q [2][$];
  int rr;
  bit pexp [2];

  task automatic reset_model();
    for (int m = 0; m < 2; m++) begin
      q[m].delete();
      pexp[m] = 1'b0;
    end
    rr = 0;
  endtask

  task automatic model_step();
    int w, p, e;
    bit hs, pop;
    logic [NP-1:0] eg, erv, eer;
    logic [31:0] ea;
    logic ewe;
    logic [BW-1:0] ebe;
    logic [MW-1:0] ewd;
    for (int m = 0; m < 2; m++) begin
      w = -1;
      if (m == 0) begin
        for (int k = 0; k < NP; k++) if (req[k]) w = k;
      end else begin
        for (int k = 0; k < NP; k++) begin
          p = (rr + k) % NP;
          if (w < 0 && req[p]) w = p;
        end
      end
      hs  = (w >= 0) && (q[m].size() < MO) && mgnt;
      pop = mrv && (q[m].size() > 0);
      eg = '0; erv = '0; eer = '0; ea = '0; ewe = 1'b0; ebe = '0; ewd = '0;
      if (hs) eg[w] = 1'b1;
      if (w >= 0) begin
        ea = addr[w]; ewe = we[w]; ebe = be[w]; ewd = wdata[w];
      end
      e = pop ? q[m][0] : 0;
      if (pop) begin
        erv[e / 4] = 1'b1;
        eer[e / 4] = merr;
      end
      chk($sformatf("m%0d mem_req", m), mreq[m], (w >= 0) && (q[m].size() < MO));
      chk($sformatf("m%0d gnt", m), gnt[m], eg);
      chk($sformatf("m%0d mem_addr", m), maddr[m], ea);
      chk($sformatf("m%0d mem_we", m), mwe[m], ewe);
      chk($sformatf("m%0d mem_be", m), mbe[m], ebe);
      chk($sformatf("m%0d mem_wdata", m), mwd[m], ewd);
      chk($sformatf("m%0d rvalid", m), rv[m], erv);
      chk($sformatf("m%0d err", m), er[m], eer);
      if (pop && (e / 4 == 0)) chk($sformatf("m%0d rdata0", m), rd[m][0], mrdata >> (32 * (e % 4)));
      chk($sformatf("m%0d rdata1", m), rd[m][1], mrdata);
      chk($sformatf("m%0d rdata2", m), rd[m][2], mrdata);
      chk($sformatf("m%0d cnt", m), cnt[m], q[m].size());
      chk($sformatf("m%0d proto", m), perr[m], pexp[m]);
      if (mrv && q[m].size() == 0) pexp[m] = 1'b1;
      if (pop) void'(q[m].pop_front());
      if (hs) begin
        q[m].push_back(w * 4 + int'(addr[w][3:2]));
        if (m == 1) rr = (w + 1) % NP;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; mrv = 1'b0; merr = 1'b0; mgnt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst m%0d cnt", m), cnt[m], 3'd0);
      chk($sformatf("rst m%0d proto", m), perr[m], 1'b0);
      chk($sformatf("rst m%0d gnt", m), gnt[m], 3'b000);
      chk($sformatf("rst m%0d rvalid", m), rv[m], 3'b000);
      chk($sformatf("rst m%0d mem_req", m), mreq[m], 1'b0);
    end
  endtask

  typedef struct {
    logic [2:0] req; logic mg, rv, er;
    logic [2:0] ga, gb, ra, rb, ea, eb;
    logic [2:0] cnt; logic pe;
    logic [31:0] aa, ab;
  } vec_t;

  vec_t tbl [19];
  logic [2:0] rr_exp [7];

  initial begin
    // Table: sequential steps from reset; expectations per instance (a = fixed, b = round-robin)
    tbl[0]  = '{3'b011, 1, 0, 0, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 32'h104, 32'h08C};
    tbl[1]  = '{3'b001, 1, 1, 0, 3'b001, 3'b001, 3'b010, 3'b001, 3'b000, 3'b000, 1, 0, 32'h08C, 32'h08C};
    tbl[2]  = '{3'b000, 1, 1, 0, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 1, 0, 32'h0,   32'h0};
    tbl[3]  = '{3'b111, 1, 0, 0, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 32'h208, 32'h104};
    tbl[4]  = '{3'b111, 1, 0, 0, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 32'h208, 32'h208};
    tbl[5]  = '{3'b111, 1, 0, 0, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 2, 0, 32'h208, 32'h08C};
    tbl[6]  = '{3'b111, 1, 0, 0, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3, 0, 32'h208, 32'h104};
    tbl[7]  = '{3'b111, 1, 1, 1, 3'b000, 3'b000, 3'b100, 3'b010, 3'b100, 3'b010, 4, 0, 32'h208, 32'h208};
    tbl[8]  = '{3'b111, 1, 0, 0, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3, 0, 32'h208, 32'h208};
    tbl[9]  = '{3'b000, 1, 1, 0, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 4, 0, 32'h0,   32'h0};
    tbl[10] = '{3'b000, 1, 1, 0, 3'b000, 3'b000, 3'b100, 3'b001, 3'b000, 3'b000, 3, 0, 32'h0,   32'h0};
    tbl[11] = '{3'b100, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2, 0, 32'h208, 32'h208};
    tbl[12] = '{3'b100, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2, 0, 32'h208, 32'h208};
    tbl[13] = '{3'b100, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2, 0, 32'h208, 32'h208};
    tbl[14] = '{3'b100, 1, 1, 0, 3'b100, 3'b100, 3'b100, 3'b010, 3'b000, 3'b000, 2, 0, 32'h208, 32'h208};
    tbl[15] = '{3'b000, 1, 1, 0, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 2, 0, 32'h0,   32'h0};
    tbl[16] = '{3'b000, 1, 1, 0, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 1, 0, 32'h0,   32'h0};
    tbl[17] = '{3'b000, 1, 1, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 32'h0,   32'h0};
    tbl[18] = '{3'b000, 1, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 32'h0,   32'h0};
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

    rst = 1'b1; req = '0; we = 3'b010; mgnt = 1'b0; mrv = 1'b0; merr = 1'b0; mrdata = RDATA_K;
    addr[0] = 32'h08C; addr[1] = 32'h104; addr[2] = 32'h208;
    for (int p = 0; p < NP; p++) begin
      be[p]    = BW'(16'h000F << (4 * p));
      wdata[p] = {4{32'hC0DE0000 + 32'(p)}};
    end
    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      req = tbl[i].req; mgnt = tbl[i].mg; mrv = tbl[i].rv; merr = tbl[i].er;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("t%0d m%0d gnt", i, m), gnt[m], m == 0 ? tbl[i].ga : tbl[i].gb);
        chk($sformatf("t%0d m%0d rvalid", i, m), rv[m], m == 0 ? tbl[i].ra : tbl[i].rb);
        chk($sformatf("t%0d m%0d err", i, m), er[m], m == 0 ? tbl[i].ea : tbl[i].eb);
        chk($sformatf("t%0d m%0d addr", i, m), maddr[m], m == 0 ? tbl[i].aa : tbl[i].ab);
        chk($sformatf("t%0d m%0d cnt", i, m), cnt[m], tbl[i].cnt);
        chk($sformatf("t%0d m%0d proto", i, m), perr[m], tbl[i].pe);
        chk($sformatf("t%0d m%0d mem_req", i, m), mreq[m], (|tbl[i].req) && (tbl[i].cnt != 3'd4));
        chk($sformatf("t%0d m%0d rdata1", i, m), rd[m][1], RDATA_K);
        if ((m == 0 ? tbl[i].ra[0] : tbl[i].rb[0]) == 1'b1)
          chk($sformatf("t%0d m%0d rdata0", i, m), rd[m][0], 128'h44444444);
      end
    end

    // Reset clears the sticky protocol error; then round-robin over a held 3'b111
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      req = 3'b111; mgnt = 1'b1; mrv = (i > 0); merr = 1'b0;
      @(negedge clk);
      chk($sformatf("rr%0d gnt", i), gnt[1], rr_exp[i]);
      chk($sformatf("rr%0d cnt", i), cnt[1], (i > 0) ? 3'd1 : 3'd0);
    end

    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      req = 3'($urandom_range(0, 7));
      for (int p = 0; p < NP; p++) begin
        addr[p]  = $urandom;
        we[p]    = 1'($urandom);
        be[p]    = BW'($urandom);
        wdata[p] = {$urandom, $urandom, $urandom, $urandom};
      end
      mgnt   = ($urandom_range(0, 3) != 0);
      mrv    = (q[0].size() > 0) && ($urandom_range(0, 9) < 4);
      merr   = ($urandom_range(0, 3) == 0);
      mrdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
